keypad_encoder_debounced: RTL and testbench

- Parametrised successor to the microwave keypad encoder: clocked, debounced, true-priority keypad-to-code encoder.
- Synchronises a one-hot/multi-hot keypad vector and resolves simultaneous presses by priority.
- Debounces press and release, then emits one registered code plus a single-cycle valid strobe per keystroke.
- Feeds the time-entry/control FSM of the microwave.

---
 rtl/keypad_encoder_debounced.sv | 174 +++++++++++++++++
 tb/tb_keypad_encoder_debounced.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder_debounced.sv
// Synchronised, debounced priority keypad encoder: one registered code + one-cycle strobe per keystroke.
// Latency: key_valid rises DEBOUNCE_CYCLES+3 edges after keypad settles; no backpressure (strobe is fire-and-forget).
// Optional auto-repeat while a key is held is built only when KEY_REPEAT_EN is defined.
module keypad_encoder_debounced #(
   parameter int N_KEYS          = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 256
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [N_KEYS-1:0] keypad,
   input  logic              enablen,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              multi_key
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [N_KEYS-1:0] KEY_ONE = N_KEYS'(1);

   if ((2 ** CODE_W) < N_KEYS || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("keypad_encoder_debounced: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } state_t;

   state_t              state_q, state_d;
   logic [N_KEYS-1:0]   sync1_q, sync1_d;
   logic [N_KEYS-1:0]   sync2_q, sync2_d;
   logic [CODE_W-1:0]   cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                valid_q, valid_d;
   logic                multi_q, multi_d;
   logic [N_KEYS-1:0]   sk;
   logic                any_key;
   logic [CODE_W-1:0]   enc;

`ifdef KEY_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
   localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
   logic [RPT_W-1:0]    rpt_q, rpt_d;
`endif

   assign sk      = sync2_q;
   assign any_key = |sk;

   // Scan from the top so the lowest set index wins.
   always_comb begin
      enc = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (sk[i]) enc = CODE_W'(i);
      end
   end

   always_comb begin
      sync1_d = keypad;
      sync2_d = sync1_q;
      multi_d = |(sk & (sk - KEY_ONE));
   end

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_d   = rpt_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_key && !enablen) begin
               state_d = DEB_PRESS;
               cand_d  = enc;
               cnt_d   = CNT_ONE;
            end
         end
         DEB_PRESS: begin
            if (enablen || !any_key) begin
               state_d = IDLE;
            end else if (enc != cand_q) begin
               cand_d = enc;
               cnt_d  = CNT_ONE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               code_d  = cand_q;
               valid_d = 1'b1;
`ifdef KEY_REPEAT_EN
               rpt_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            // Other keys appearing while one is held are deliberately ignored.
            if (!any_key) begin
               state_d = DEB_RELEASE;
               cnt_d   = CNT_ONE;
            end
`ifdef KEY_REPEAT_EN
            else if (enablen) begin
               rpt_d = '0;
            end else if (rpt_q == RPT_LAST) begin
               valid_d = 1'b1;
               rpt_d   = '0;
            end else begin
               rpt_d = rpt_q + RPT_ONE;
            end
`endif
         end
         DEB_RELEASE: begin
            // enablen is not consulted here so a held key cannot re-strobe when enable returns.
            if (any_key) begin
               state_d = PRESSED;
`ifdef KEY_REPEAT_EN
               rpt_d   = '0;
`endif
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
      end
   end

`ifdef KEY_REPEAT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rpt_q <= '0;
      else         rpt_q <= rpt_d;
   end
`endif

   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = (state_q == PRESSED) || (state_q == DEB_RELEASE);
   assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_encoder_debounced.sv
// Randomised and directed bench for keypad_encoder_debounced against a run-length reference model.
module tb_keypad_encoder_debounced;

   localparam int NK = 10;
   localparam int CW = 4;
   localparam int DB = 4;
   localparam int RP = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic [NK-1:0] keypad;
   logic          enablen;
   logic [CW-1:0] key_code;
   logic          key_valid;
   logic          key_held;
   logic          multi_key;

   keypad_encoder_debounced #(
      .N_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)
   ) dut (
      .clk(clk), .resetn(resetn), .keypad(keypad), .enablen(enablen),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: synchroniser pipe plus run lengths of qualifying samples.
   logic [NK-1:0] m_s1, m_s2;
   int  run, run_key, rel_run, rpt, m_code;
   bit  m_held, m_valid, m_multi;

   int  step_no, first_valid_step, nvalid, held_steps;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0;
      run = 0; run_key = 0; rel_run = 0; rpt = 0; m_code = 0;
      m_held = 0; m_valid = 0; m_multi = 0;
   endtask

   task automatic model_edge(input logic [NK-1:0] kp);
      logic [NK-1:0] sk;
      int  enc;
      bit  anyk;
      sk   = m_s2;
      anyk = (sk != '0);
      enc  = 0;
      for (int i = 0; i < NK; i++) begin
         if (sk[i]) begin
            enc = i;
            break;
         end
      end
      m_multi = ($countones(sk) > 1);
      m_valid = 0;
      if (!m_held) begin
         if (anyk && !enablen) begin
            if (run > 0 && enc == run_key) run++;
            else begin
               run     = 1;
               run_key = enc;
            end
         end else begin
            run = 0;
         end
         if (run == DB + 1) begin
            m_held  = 1;
            m_code  = run_key;
            m_valid = 1;
            run     = 0;
            rel_run = 0;
            rpt     = 0;
         end
      end else if (!anyk) begin
         rel_run++;
         if (rel_run == DB + 1) begin
            m_held  = 0;
            rel_run = 0;
            run     = 0;
         end
      end else begin
         if (rel_run > 0) rpt = 0;
`ifdef KEY_REPEAT_EN
         else if (enablen) rpt = 0;
         else if (rpt == RP - 1) begin
            m_valid = 1;
            rpt     = 0;
         end else rpt++;
`endif
         rel_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = kp;
   endtask

   task automatic clr();
      step_no = 0; first_valid_step = 0; nvalid = 0; held_steps = 0;
   endtask

   // One clock: drive at negedge, advance model at posedge, compare at next negedge.
   task automatic step(input logic [NK-1:0] kp, input logic en);
      keypad  = kp;
      enablen = en;
      @(posedge clk);
      model_edge(kp);
      @(negedge clk);
      check("key_code",  {28'd0, key_code}, m_code);
      check("key_valid", {31'd0, key_valid}, {31'd0, m_valid});
      check("key_held",  {31'd0, key_held},  {31'd0, m_held});
      check("multi_key", {31'd0, multi_key}, {31'd0, m_multi});
      step_no++;
      if (key_valid === 1'b1) begin
         nvalid++;
         if (first_valid_step == 0) first_valid_step = step_no;
      end
      if (key_held === 1'b1) held_steps++;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      check("rst_code",  {28'd0, key_code}, 0);
      check("rst_valid", {31'd0, key_valid}, 0);
      check("rst_held",  {31'd0, key_held}, 0);
      check("rst_multi", {31'd0, multi_key}, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      logic [NK-1:0] kp;
      logic          en;
      int            len, kind;
      keypad  = '0;
      enablen = 1'b0;
      do_reset();

      // Single key 3: strobe on step DB+3, held through DB+2 clocks after release.
      clr();
      repeat (7) step(10'b0000001000, 1'b0);
      check("k3_latency", first_valid_step, 7);
      check("k3_code", {28'd0, key_code}, 3);
      held_steps = 0;
      repeat (10) step('0, 1'b0);
      check("k3_held_after_release", held_steps, 6);
      check("k3_strobes", nvalid, 1);

      // Two keys at once: lowest index wins, multi flag raised.
      clr();
      repeat (7) step(10'b0000100100, 1'b0);
      check("multi_code", {28'd0, key_code}, 2);
      check("multi_flag", {31'd0, multi_key}, 1);
      repeat (10) step('0, 1'b0);
      check("multi_strobes", nvalid, 1);

      // Key 5 with periodic zero glitches, then clean, then a short release glitch.
      clr();
      for (int i = 0; i < 12; i++) step((i % 3 == 2) ? '0 : 10'b0000100000, 1'b0);
      check("glitch_no_strobe", nvalid, 0);
      repeat (7) step(10'b0000100000, 1'b0);
      check("glitch_accept", nvalid, 1);
      check("glitch_code", {28'd0, key_code}, 5);
      repeat (2) step('0, 1'b0);
      repeat (3) step(10'b0000100000, 1'b0);
      repeat (10) step('0, 1'b0);
      check("release_glitch_strobes", nvalid, 1);

      // Key 7 with enable blocked, then enabled while still held.
      clr();
      repeat (15) step(10'b0010000000, 1'b1);
      check("disabled_no_strobe", nvalid, 0);
      clr();
      repeat (6) step(10'b0010000000, 1'b0);
      check("enable_latency", first_valid_step, 5);
      check("enable_code", {28'd0, key_code}, 7);
      repeat (10) step('0, 1'b1);
      check("release_while_disabled", {31'd0, key_held}, 0);
      check("enable_strobes", nvalid, 1);

      // Reset in the middle of a press debounce.
      clr();
      repeat (4) step(10'b0000000010, 1'b0);
      keypad = '0;
      do_reset();
      repeat (12) step('0, 1'b0);
      check("reset_mid_debounce", nvalid, 0);

      // Long hold of key 9: repeats only when the feature is built.
      clr();
      repeat (30) step(10'b1000000000, 1'b0);
      check("hold9_code", {28'd0, key_code}, 9);
`ifdef KEY_REPEAT_EN
      check("hold9_strobes", nvalid, 3);
`else
      check("hold9_strobes", nvalid, 1);
`endif
      repeat (10) step('0, 1'b0);

      // Random segments: idle, single keys, multi-hot, bouncy keys, enable toggling, rare resets.
      for (int s = 0; s < 300; s++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 14);
         en   = ($urandom_range(0, 7) == 0);
         if (kind <= 2)      kp = '0;
         else if (kind <= 6) kp = NK'(1) << $urandom_range(0, NK - 1);
         else                kp = NK'($urandom());
         if ($urandom_range(0, 59) == 0) begin
            keypad = '0;
            do_reset();
         end
         for (int c = 0; c < len; c++) begin
            if (kind == 9 && $urandom_range(0, 3) == 0) step('0, en);
            else                                        step(kp, en);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
